// File: rtl/game_pkg.sv
// Shared types and constants for the asteroid-avoider game phase sequencer.
package game_pkg;

   localparam int PHASE_W = 2;
   localparam int FRAME_N = 16;

   typedef logic [FRAME_N-1:0][FRAME_N-1:0] frame_t;

   typedef enum logic [PHASE_W-1:0] {
      ATTRACT  = 2'b00,
      PLAY     = 2'b01,
      EXPLODE  = 2'b10,
      GAMEOVER = 2'b11
   } phase_t;

   function automatic logic is_end_phase(input phase_t p);
      return (p == EXPLODE) || (p == GAMEOVER);
   endfunction

endpackage

// File: rtl/phase_tick_timer.sv
// Tick divider plus a saturating count of ticks seen since the last clear.
module phase_tick_timer #(
   parameter int TICKDIV = 25
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       clr,
   output logic       tick,
   output logic [3:0] tcount
);

   logic [TICKDIV-1:0] div_q;
   logic [3:0]         tcount_q;

   assign tick   = &div_q;
   assign tcount = tcount_q;

   // clr has priority so a newly entered state always gets a full tick period.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         div_q    <= '0;
         tcount_q <= '0;
      end else if (clr) begin
         div_q    <= '0;
         tcount_q <= '0;
      end else begin
         div_q <= div_q + 1'b1;
         if (tick && (tcount_q != 4'hF))
            tcount_q <= tcount_q + 4'd1;
      end
   end

endmodule

// File: rtl/game_phase_controller.sv
// Game phase FSM: attract -> play -> explode -> game over, with enables and
// a registered 16x16 frame mux feeding the LED driver.
module game_phase_controller
   import game_pkg::*;
#(
   parameter int TICKDIV       = 25,
   parameter int EXPLODE_TICKS = 7,
   parameter int LOCK_TICKS    = 4
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               start_btn,
   input  logic               collision,
   input  frame_t             PixSTART,
   input  frame_t             PixPLAY,
   input  frame_t             PixEND,
   output frame_t             PixOUT,
   output logic               PLAYen,
   output logic               ENDen,
   output logic [PHASE_W-1:0] phase
);

   localparam logic [3:0] EXP_LAST = 4'(EXPLODE_TICKS - 1);
   localparam logic [3:0] LOCK_N   = 4'(LOCK_TICKS);

   phase_t     state_q, state_d;
   logic       btn_prev_q;
   logic       play_en_q;
   logic       end_en_q;
   frame_t     pix_q, pix_d;
   logic       start_rise;
   logic       tick;
   logic [3:0] tcount;
   logic       clr;

   assign start_rise = start_btn & ~btn_prev_q;
   assign clr        = (state_d != state_q);

   phase_tick_timer #(
      .TICKDIV (TICKDIV)
   ) u_timer (
      .CLK    (CLK),
      .RST    (RST),
      .clr    (clr),
      .tick   (tick),
      .tcount (tcount)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ATTRACT:  if (start_rise) state_d = PLAY;
         PLAY:     if (collision) state_d = EXPLODE;
         EXPLODE:  if (tick && (tcount == EXP_LAST)) state_d = GAMEOVER;
         GAMEOVER: if (start_rise && (tcount >= LOCK_N)) state_d = ATTRACT;
         default:  state_d = ATTRACT;
      endcase
   end

   // The mux follows the current state, so a new source shows one cycle after a switch.
   always_comb begin
      pix_d = PixEND;
      case (state_q)
         ATTRACT: pix_d = PixSTART;
         PLAY:    pix_d = PixPLAY;
         default: pix_d = PixEND;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= ATTRACT;
         btn_prev_q <= 1'b1;
         play_en_q  <= 1'b0;
         end_en_q   <= 1'b0;
         pix_q      <= '0;
      end else begin
         state_q    <= state_d;
         btn_prev_q <= start_btn;
         play_en_q  <= (state_d == PLAY);
         end_en_q   <= is_end_phase(state_d);
         pix_q      <= pix_d;
      end
   end

   assign PixOUT = pix_q;
   assign PLAYen = play_en_q;
   assign ENDen  = end_en_q;
   assign phase  = state_q;

endmodule

// File: tb/tb_game_phase_controller.sv
// Self-checking bench: directed scenarios plus random play against a cycle-count model.
module tb_game_phase_controller;
   import game_pkg::*;

   localparam int TICKDIV = 2;
   localparam int EXP_T   = 3;
   localparam int LOCK_T  = 2;

   logic         CLK = 1'b0;
   logic         RST;
   logic         start_btn;
   logic         collision;
   frame_t       PixSTART, PixPLAY, PixEND, PixOUT;
   logic         PLAYen, ENDen;
   logic [1:0]   phase;

   int n_checks = 0;
   int n_fail   = 0;

   // model: phase, cycles spent in the current phase, previous button, expected frame
   logic [1:0] m_phase;
   int         m_cyc;
   logic       m_prev;
   frame_t     m_pix;

   game_phase_controller #(
      .TICKDIV       (TICKDIV),
      .EXPLODE_TICKS (EXP_T),
      .LOCK_TICKS    (LOCK_T)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .start_btn (start_btn),
      .collision (collision),
      .PixSTART  (PixSTART),
      .PixPLAY   (PixPLAY),
      .PixEND    (PixEND),
      .PixOUT    (PixOUT),
      .PLAYen    (PLAYen),
      .ENDen     (ENDen),
      .phase     (phase)
   );

   always #5 CLK = ~CLK;

   function automatic frame_t rand_frame();
      frame_t f;
      for (int i = 0; i < 8; i++) f[i*2 +: 2] = {$urandom(), $urandom()};
      return f;
   endfunction

   task automatic model_reset();
      m_phase = 2'd0;
      m_cyc   = 0;
      m_prev  = 1'b1;
      m_pix   = '0;
   endtask

   // Advance one clock edge in both DUT and model, then settle 1 time unit.
   task automatic step();
      logic       rise;
      logic [1:0] nxt;
      int         ticks_in;
      @(posedge CLK);
      rise     = start_btn && !m_prev;
      m_prev   = start_btn;
      m_pix    = (m_phase == 2'd0) ? PixSTART : (m_phase == 2'd1) ? PixPLAY : PixEND;
      ticks_in = m_cyc / (1 << TICKDIV);
      if (ticks_in > 15) ticks_in = 15;
      nxt = m_phase;
      case (m_phase)
         2'd0: if (rise) nxt = 2'd1;
         2'd1: if (collision) nxt = 2'd2;
         2'd2: if (m_cyc + 1 == EXP_T * (1 << TICKDIV)) nxt = 2'd3;
         default: if (rise && ticks_in >= LOCK_T) nxt = 2'd0;
      endcase
      m_cyc   = (nxt != m_phase) ? 0 : m_cyc + 1;
      m_phase = nxt;
      #1;
   endtask

   task automatic test_reset();
      PixSTART = {16{16'hA5A5}};
      PixPLAY  = {16{16'h3C3C}};
      PixEND   = {16{16'h0FF0}};
      RST = 1'b0; start_btn = 1'b1; collision = 1'b0;
      model_reset();
      repeat (2) @(negedge CLK);
      n_checks++;
      if (phase !== 2'b00 || PLAYen !== 1'b0 || ENDen !== 1'b0 || PixOUT !== '0) begin
         n_fail++;
         $display("FAIL reset_state: phase=%b PLAYen=%b ENDen=%b PixOUT=%h, required 00 0 0 zero", phase, PLAYen, ENDen, PixOUT);
      end
      RST = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         n_checks++;
         if (phase !== 2'b00 || PLAYen !== 1'b0 || PixOUT !== m_pix) begin
            n_fail++;
            $display("FAIL held_button cyc%0d: phase=%b PLAYen=%b, required 00 0", i, phase, PLAYen);
         end
      end
      start_btn = 1'b0; step();
      start_btn = 1'b1; step();
      n_checks++;
      if (PLAYen !== 1'b1 || phase !== 2'b01 || PixOUT !== PixSTART) begin
         n_fail++;
         $display("FAIL start_press: phase=%b PLAYen=%b pix_start=%b, required 01 1 1", phase, PLAYen, PixOUT === PixSTART);
      end
      start_btn = 1'b0; step();
      n_checks++;
      if (PixOUT !== PixPLAY) begin
         n_fail++;
         $display("FAIL play_frame: PixOUT=%h, required %h", PixOUT, PixPLAY);
      end
      $display("test_reset done at %0t", $time);
   endtask

   task automatic test_collision();
      bit ok_end = 1'b1;
      bit early  = 1'b0;
      collision = 1'b1; step();
      collision = 1'b0;
      n_checks++;
      if (phase !== 2'b10 || ENDen !== 1'b1 || PLAYen !== 1'b0) begin
         n_fail++;
         $display("FAIL collision_enter: phase=%b ENDen=%b PLAYen=%b, required 10 1 0", phase, ENDen, PLAYen);
      end
      for (int k = 1; k <= 12; k++) begin
         step();
         if (ENDen !== 1'b1) ok_end = 1'b0;
         if (k < 12 && phase !== 2'b10) early = 1'b1;
         n_checks++;
         if (phase !== m_phase || PixOUT !== m_pix) begin
            n_fail++;
            $display("FAIL explode_model k%0d: phase=%b, required %b", k, phase, m_phase);
         end
      end
      n_checks++;
      if (phase !== 2'b11 || early || !ok_end) begin
         n_fail++;
         $display("FAIL explode_length: phase=%b early_exit=%b enden_glitch=%b, required 11 0 0", phase, early, !ok_end);
      end
      $display("test_collision done at %0t", $time);
   endtask

   task automatic test_gameover_lock();
      for (int c = 0; c < 12; c++) begin
         start_btn = (c == 3 || c == 10);
         step();
         n_checks++;
         if (phase !== m_phase || PLAYen !== (m_phase == 2'd1) || ENDen !== m_phase[1] || PixOUT !== m_pix) begin
            n_fail++;
            $display("FAIL gameover_model c%0d: phase=%b ENDen=%b, required %b %b", c, phase, ENDen, m_phase, m_phase[1]);
         end
         if (c == 3) begin
            n_checks++;
            if (phase !== 2'b11) begin
               n_fail++;
               $display("FAIL locked_press: phase=%b, required 11", phase);
            end
         end
         if (c == 10) begin
            n_checks++;
            if (phase !== 2'b00 || ENDen !== 1'b0) begin
               n_fail++;
               $display("FAIL restart_press: phase=%b ENDen=%b, required 00 0", phase, ENDen);
            end
         end
      end
      n_checks++;
      if (PixOUT !== PixSTART) begin
         n_fail++;
         $display("FAIL attract_frame: PixOUT=%h, required %h", PixOUT, PixSTART);
      end
      start_btn = 1'b0;
      $display("test_gameover_lock done at %0t", $time);
   endtask

   task automatic test_same_cycle();
      start_btn = 1'b1; step();
      start_btn = 1'b0; step();
      start_btn = 1'b1; collision = 1'b1; step();
      n_checks++;
      if (phase !== 2'b10 || PLAYen !== 1'b0 || ENDen !== 1'b1 || phase !== m_phase) begin
         n_fail++;
         $display("FAIL collision_wins: phase=%b PLAYen=%b ENDen=%b, required 10 0 1", phase, PLAYen, ENDen);
      end
      start_btn = 1'b0; collision = 1'b0;
      $display("test_same_cycle done at %0t", $time);
   endtask

   task automatic test_async_reset();
      repeat (5) step();
      #2 RST = 1'b0;
      #1;
      n_checks++;
      if (phase !== 2'b00 || ENDen !== 1'b0 || PLAYen !== 1'b0 || PixOUT !== '0) begin
         n_fail++;
         $display("FAIL async_reset: phase=%b ENDen=%b PLAYen=%b PixOUT=%h, required 00 0 0 zero", phase, ENDen, PLAYen, PixOUT);
      end
      model_reset();
      start_btn = 1'b1;
      @(negedge CLK) RST = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         n_checks++;
         if (phase !== 2'b00 || phase !== m_phase || PixOUT !== m_pix) begin
            n_fail++;
            $display("FAIL post_reset_wait cyc%0d: phase=%b, required 00", i, phase);
         end
      end
      start_btn = 1'b0; step();
      start_btn = 1'b1; step();
      n_checks++;
      if (phase !== 2'b01 || PLAYen !== 1'b1) begin
         n_fail++;
         $display("FAIL fresh_press: phase=%b PLAYen=%b, required 01 1", phase, PLAYen);
      end
      start_btn = 1'b0;
      $display("test_async_reset done at %0t", $time);
   endtask

   task automatic test_random();
      int seen[4] = '{0, 0, 0, 0};
      for (int i = 0; i < 800; i++) begin
         start_btn = ($urandom_range(0, 5) == 0);
         collision = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 7) == 0) PixSTART = rand_frame();
         if ($urandom_range(0, 7) == 0) PixPLAY  = rand_frame();
         if ($urandom_range(0, 7) == 0) PixEND   = rand_frame();
         step();
         seen[m_phase]++;
         n_checks++;
         if (phase !== m_phase || PLAYen !== (m_phase == 2'd1) || ENDen !== m_phase[1] || PixOUT !== m_pix) begin
            n_fail++;
            $display("FAIL random cyc%0d: phase=%b PLAYen=%b ENDen=%b pix_ok=%b, required %b %b %b 1",
                     i, phase, PLAYen, ENDen, PixOUT === m_pix, m_phase, m_phase == 2'd1, m_phase[1]);
         end
      end
      start_btn = 1'b0; collision = 1'b0;
      $display("test_random done: cycles per phase %0d %0d %0d %0d", seen[0], seen[1], seen[2], seen[3]);
   endtask

   initial begin
      test_reset();
      test_collision();
      test_gameover_lock();
      test_same_cycle();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
